// File: rtl/pid_mc_if.sv
// pid_mc_if: sample/gain inputs and control-output bus of the multi-channel PID controller.
// master drives the snapshot inputs, slave (the controller) drives co/valid/busy.
interface pid_mc_if #(
  parameter int unsigned NBITS = 16,
  parameter int unsigned NCH   = 4,
  parameter int unsigned KBITS = 16
);
  logic                   start_i;
  logic [NCH*NBITS-1:0]   sp_i;
  logic [NCH*NBITS-1:0]   pv_i;
  logic [KBITS-1:0]       kp_i;
  logic [KBITS-1:0]       ki_i;
  logic [KBITS-1:0]       kd_i;
  logic [NBITS-2:0]       ilim_i;
  logic [NCH*NBITS-1:0]   co_o;
  logic                   valid_o;
  logic                   busy_o;

  modport master (
    output start_i, sp_i, pv_i, kp_i, ki_i, kd_i, ilim_i,
    input  co_o, valid_o, busy_o
  );

  modport slave (
    input  start_i, sp_i, pv_i, kp_i, ki_i, kd_i, ilim_i,
    output co_o, valid_o, busy_o
  );
endinterface

// File: rtl/pid_mc.sv
// pid_mc: time-multiplexed multi-channel PID controller sharing one MAC datapath.
// Define PID_DERIV_EN to build the derivative term (MUL_D state, kd gain, per-channel eprev).
module pid_mc #(
  parameter int unsigned NBITS = 16,
  parameter int unsigned NCH   = 4,
  parameter int unsigned KBITS = 16,
  parameter int unsigned FRAC  = 8
) (
  input  logic    clk,
  input  logic    rst,
  input  logic    clr,
  input  logic    en,
  pid_mc_if.slave bus
);
  localparam int unsigned ACCW = 2 * NBITS + KBITS;
  localparam int unsigned CHW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CHW-1:0] LastCh = CHW'(NCH - 1);

  typedef logic signed [NBITS-1:0] word_t;
  typedef logic signed [NBITS:0]   wide_t;
  typedef logic signed [KBITS-1:0] gain_t;
  typedef logic signed [ACCW-1:0]  acc_t;

  localparam word_t WordMax = {1'b0, {(NBITS-1){1'b1}}};
  localparam word_t WordMin = {1'b1, {(NBITS-1){1'b0}}};

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StMulP,
    StMulI,
`ifdef PID_DERIV_EN
    StMulD,
`endif
    StOut
  } state_e;

  function automatic word_t sat_wide(wide_t x);
    if (x[NBITS] == x[NBITS-1]) return x[NBITS-1:0];
    return x[NBITS] ? WordMin : WordMax;
  endfunction

  // Arithmetic shift floors toward -inf before saturating to the output width.
  function automatic word_t sat_acc(acc_t x);
    acc_t s;
    s = x >>> FRAC;
    if ((&s[ACCW-1:NBITS-1]) || (~|s[ACCW-1:NBITS-1])) return s[NBITS-1:0];
    return s[ACCW-1] ? WordMin : WordMax;
  endfunction

  state_e               state_q, state_d;
  logic [CHW-1:0]       ch_q;
  word_t                sp_q    [NCH];
  word_t                pv_q    [NCH];
  word_t                integ_q [NCH];
  gain_t                kp_q, ki_q;
  word_t                ilim_q;
  word_t                e_q, ip_q;
  acc_t                 acc_q, acc_d;
  logic [NCH*NBITS-1:0] co_q;
  logic                 valid_q, busy_q;

  wide_t e_raw, i_sum, lim;
  word_t e_sat, i_next;

`ifdef PID_DERIV_EN
  gain_t kd_q;
  word_t eprev_q [NCH];
  wide_t d_q, d_raw;
`else
  logic unused_kd;
  assign unused_kd = ^bus.kd_i;
`endif

  // Error, clamped integrator and derivative for the channel in LOAD.
  always_comb begin
    e_raw = wide_t'(sp_q[ch_q]) - wide_t'(pv_q[ch_q]);
    e_sat = sat_wide(e_raw);
    i_sum = wide_t'(integ_q[ch_q]) + wide_t'(e_sat);
    lim   = wide_t'(ilim_q);
    if (i_sum > lim)       i_next = lim[NBITS-1:0];
    else if (i_sum < -lim) i_next = word_t'(-lim);
    else                   i_next = i_sum[NBITS-1:0];
`ifdef PID_DERIV_EN
    d_raw = wide_t'(e_sat) - wide_t'(eprev_q[ch_q]);
`endif
  end

  always_comb begin
    acc_d = acc_q;
    case (state_q)
      StMulP:  acc_d = acc_t'(kp_q) * acc_t'(e_q);
      StMulI:  acc_d = acc_q + acc_t'(ki_q) * acc_t'(ip_q);
`ifdef PID_DERIV_EN
      StMulD:  acc_d = acc_q + acc_t'(kd_q) * acc_t'(d_q);
`endif
      default: acc_d = acc_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (bus.start_i) state_d = StLoad;
      StLoad:  state_d = StMulP;
      StMulP:  state_d = StMulI;
`ifdef PID_DERIV_EN
      StMulI:  state_d = StMulD;
      StMulD:  state_d = StOut;
`else
      StMulI:  state_d = StOut;
`endif
      StOut:   state_d = (ch_q == LastCh) ? StIdle : StLoad;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     state_q <= StIdle;
    else if (clr) state_q <= StIdle;
    else if (en)  state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ch_q    <= '0;
      kp_q    <= '0;
      ki_q    <= '0;
      ilim_q  <= '0;
      e_q     <= '0;
      ip_q    <= '0;
      acc_q   <= '0;
      co_q    <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        sp_q[k]    <= '0;
        pv_q[k]    <= '0;
        integ_q[k] <= '0;
      end
`ifdef PID_DERIV_EN
      kd_q <= '0;
      d_q  <= '0;
      for (int k = 0; k < NCH; k++) eprev_q[k] <= '0;
`endif
    end else if (clr) begin
      ch_q    <= '0;
      co_q    <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      for (int k = 0; k < NCH; k++) integ_q[k] <= '0;
`ifdef PID_DERIV_EN
      for (int k = 0; k < NCH; k++) eprev_q[k] <= '0;
`endif
    end else if (en) begin
      valid_q <= 1'b0;
      acc_q   <= acc_d;
      case (state_q)
        StIdle: begin
          if (bus.start_i) begin
            for (int k = 0; k < NCH; k++) begin
              sp_q[k] <= bus.sp_i[k*NBITS +: NBITS];
              pv_q[k] <= bus.pv_i[k*NBITS +: NBITS];
            end
            kp_q   <= bus.kp_i;
            ki_q   <= bus.ki_i;
            ilim_q <= {1'b0, bus.ilim_i};
            ch_q   <= '0;
            busy_q <= 1'b1;
`ifdef PID_DERIV_EN
            kd_q   <= bus.kd_i;
`endif
          end
        end
        StLoad: begin
          e_q           <= e_sat;
          ip_q          <= i_next;
          integ_q[ch_q] <= i_next;
`ifdef PID_DERIV_EN
          d_q           <= d_raw;
          eprev_q[ch_q] <= e_sat;
`endif
        end
        StOut: begin
          co_q[ch_q*NBITS +: NBITS] <= sat_acc(acc_q);
          if (ch_q == LastCh) begin
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            ch_q <= ch_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.co_o    = co_q;
  assign bus.valid_o = valid_q;
  assign bus.busy_o  = busy_q;
endmodule

// File: tb/tb_pid_mc.sv
// tb_pid_mc: table-driven bench for pid_mc with an expected-output scoreboard queue.
// Expectations follow the build: derivative term and per-channel latency depend on PID_DERIV_EN.
module tb_pid_mc;
  localparam int NB = 16;
  localparam int NC = 4;
  localparam int KB = 16;
  localparam int FR = 8;
`ifdef PID_DERIV_EN
  localparam int Steps = 5;
  localparam bit Deriv = 1'b1;
`else
  localparam int Steps = 4;
  localparam bit Deriv = 1'b0;
`endif
  localparam int Lat = Steps * NC;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clr = 1'b0;
  logic en  = 1'b1;

  pid_mc_if #(.NBITS(NB), .NCH(NC), .KBITS(KB)) bus ();

  pid_mc #(.NBITS(NB), .NCH(NC), .KBITS(KB), .FRAC(FR)) dut (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .en  (en),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    bit                  clr;
    int                  kp;
    int                  ki;
    int                  kd;
    int                  ilim;
    logic [NC-1:0][31:0] sp;
    logic [NC-1:0][31:0] pv;
    logic [NC-1:0][31:0] co;
  } vec_t;

  vec_t vecs[$];
  int   sbq[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input bit c, input int kp, input int ki, input int kd,
                              input int ilim, input int s0, input int s1, input int s2,
                              input int s3, input int p0, input int p1, input int p2,
                              input int p3, input int c0, input int c1, input int c2,
                              input int c3);
    vec_t v;
    v.clr = c; v.kp = kp; v.ki = ki; v.kd = kd; v.ilim = ilim;
    v.sp[0] = s0; v.sp[1] = s1; v.sp[2] = s2; v.sp[3] = s3;
    v.pv[0] = p0; v.pv[1] = p1; v.pv[2] = p2; v.pv[3] = p3;
    v.co[0] = c0; v.co[1] = c1; v.co[2] = c2; v.co[3] = c3;
    return v;
  endfunction

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic signed [63:0] co_of(input int k);
    logic signed [NB-1:0] s;
    s = bus.co_o[k*NB +: NB];
    return s;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_seq(input vec_t v, input bit push);
    if (v.clr) begin
      clr = 1'b1;
      cyc();
      clr = 1'b0;
    end
    bus.kp_i   = 16'(v.kp);
    bus.ki_i   = 16'(v.ki);
    bus.kd_i   = 16'(v.kd);
    bus.ilim_i = 15'(v.ilim);
    for (int k = 0; k < NC; k++) begin
      bus.sp_i[k*NB +: NB] = v.sp[k][NB-1:0];
      bus.pv_i[k*NB +: NB] = v.pv[k][NB-1:0];
      if (push) sbq.push_back(int'(v.co[k]));
    end
    bus.start_i = 1'b1;
    cyc();
    bus.start_i = 1'b0;
    check("accept_busy", bus.busy_o, 1);
  endtask

  task automatic finish_seq(input string name, input int lat, input int already);
    int n;
    bit bad_busy;
    int e;
    n = already;
    bad_busy = 1'b0;
    while (bus.valid_o !== 1'b1 && n < lat + 40) begin
      if (bus.busy_o !== 1'b1) bad_busy = 1'b1;
      cyc();
      n++;
    end
    check({name, "_busy_hold"}, bad_busy, 0);
    check({name, "_latency"}, n, lat);
    if (bus.valid_o === 1'b1) begin
      check({name, "_busy_fall"}, bus.busy_o, 0);
      for (int k = 0; k < NC; k++) begin
        e = sbq.pop_front();
        check($sformatf("%s_co%0d", name, k), co_of(k), e);
      end
      cyc();
      check({name, "_valid_pulse"}, bus.valid_o, 0);
    end else begin
      for (int k = 0; k < NC; k++) void'(sbq.pop_front());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    bit   seen;

    // clr, kp, ki, kd, ilim, sp[0..3], pv[0..3], expected co[0..3]
    vecs.push_back(mk(1, 'h0100, 0, 0, 1000, 100, 7, -5, -20, 40, 10, -5, 30, 60, -3, 0, -50));
    vecs.push_back(mk(1, 'h0080, 0, 0, 1000, 10, -10, 3, -3, 0, 0, 0, 0, 5, -5, 1, -2));
    vecs.push_back(mk(1, 'h0100, 0, 0, 1000, 32767, -32768, 0, -1, -32768, 32767, 0, 0,
                      32767, -32768, 0, -1));
    vecs.push_back(mk(1, 'h7FFF, 0, 0, 1000, 1000, -1000, 1, 0, 0, 0, 0, 0,
                      32767, -32768, 127, 0));
    vecs.push_back(mk(1, 'hFF00, 0, 0, 1000, 5, -32768, 3, -3, 0, 0, 0, 0, -5, 32767, -3, 3));
    vecs.push_back(mk(1, 0, 'h0100, 0, 1000, 300, -300, 0, 10, 0, 0, 0, 0, 300, -300, 0, 10));
    vecs.push_back(mk(0, 0, 'h0100, 0, 1000, 300, -300, 0, 10, 0, 0, 0, 0, 600, -600, 0, 20));
    vecs.push_back(mk(0, 0, 'h0100, 0, 1000, 300, -300, 0, 10, 0, 0, 0, 0, 900, -900, 0, 30));
    vecs.push_back(mk(0, 0, 'h0100, 0, 1000, 300, -300, 0, 10, 0, 0, 0, 0, 1000, -1000, 0, 40));
    vecs.push_back(mk(0, 0, 'h0100, 0, 500, 300, -300, 0, 10, 0, 0, 0, 0, 500, -500, 0, 50));
    vecs.push_back(mk(1, 'h0100, 'h0080, 0, 1000, 100, -40, 0, 0, 0, 0, 0, 0, 150, -60, 0, 0));

    // Reset held with random inputs and a live start strobe.
    bus.start_i = 1'b1;
    bus.sp_i    = {$urandom, $urandom};
    bus.pv_i    = {$urandom, $urandom};
    bus.kp_i    = 16'($urandom);
    bus.ki_i    = 16'($urandom);
    bus.kd_i    = 16'($urandom);
    bus.ilim_i  = 15'($urandom);
    repeat (4) cyc();
    check("rst_co", bus.co_o, 0);
    check("rst_valid", bus.valid_o, 0);
    check("rst_busy", bus.busy_o, 0);
    bus.start_i = 1'b0;
    rst = 1'b1;
    repeat (5) cyc();
    check("idle_co", bus.co_o, 0);
    check("idle_valid", bus.valid_o, 0);
    check("idle_busy", bus.busy_o, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      start_seq(vecs[i], 1'b1);
      finish_seq($sformatf("vec%0d", i), Lat, 0);
    end

    // Derivative term: D = e - eprev per channel.
    v = mk(1, 0, 0, 'h0100, 1000, 50, -10, 0, 0, 0, 0, 0, 0,
           Deriv ? 50 : 0, Deriv ? -10 : 0, 0, 0);
    start_seq(v, 1'b1);
    finish_seq("deriv1", Lat, 0);
    v = mk(0, 0, 0, 'h0100, 1000, 80, 20, 0, 0, 0, 0, 0, 0,
           Deriv ? 30 : 0, Deriv ? 30 : 0, 0, 0);
    start_seq(v, 1'b1);
    finish_seq("deriv2", Lat, 0);

    // Three frozen cycles mid-sequence push valid out by three.
    v = mk(1, 'h0100, 0, 0, 1000, 10, 20, 30, 40, 0, 0, 0, 0, 10, 20, 30, 40);
    start_seq(v, 1'b1);
    repeat (2) cyc();
    en = 1'b0;
    repeat (3) cyc();
    en = 1'b1;
    finish_seq("stall", Lat + 3, 5);

    // Start while busy is dropped, and input changes after acceptance are invisible.
    v = mk(1, 'h0100, 0, 0, 1000, 100, 7, -5, -20, 40, 10, -5, 30, 60, -3, 0, -50);
    start_seq(v, 1'b1);
    bus.start_i = 1'b1;
    bus.sp_i    = {4{16'd1234}};
    bus.kp_i    = 16'h0200;
    repeat (3) cyc();
    bus.start_i = 1'b0;
    finish_seq("busy_start", Lat, 3);
    seen = 1'b0;
    repeat (3) begin
      if (bus.busy_o !== 1'b0) seen = 1'b1;
      cyc();
    end
    check("no_queued_start", seen, 0);

    // clr at cycle 7 aborts the sequence and zeroes the integrators.
    v = mk(1, 0, 'h0100, 0, 1000, 300, -300, 0, 10, 0, 0, 0, 0, 300, -300, 0, 10);
    start_seq(v, 1'b0);
    repeat (6) cyc();
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    check("clr_busy", bus.busy_o, 0);
    check("clr_valid", bus.valid_o, 0);
    check("clr_co", bus.co_o, 0);
    seen = 1'b0;
    repeat (30) begin
      if (bus.valid_o !== 1'b0) seen = 1'b1;
      cyc();
    end
    check("clr_no_valid", seen, 0);
    v.clr = 1'b0;
    start_seq(v, 1'b1);
    finish_seq("after_clr", Lat, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
